// File: rtl/sevenseg_scan_if.sv
// Time bus between a stopwatch core and the display driver: binary MM/SS plus
// adjust controls going in, multiplexed 7-segment drive coming back out.
interface sevenseg_scan_if;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       adj;
  logic       sel;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  modport master (
    output minutes, seconds, adj, sel,
    input  seg, an, dp
  );

  modport slave (
    input  minutes, seconds, adj, sel,
    output seg, an, dp
  );
endinterface

// File: rtl/sevenseg_scan.sv
// 4-digit multiplexed common-anode MM.SS display driver with per-frame snapshot
// of the time inputs and blinking of the field being adjusted.
module sevenseg_scan #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic           clk,
  input  logic           rstBtn,
  sevenseg_scan_if.slave bus
);

  localparam int SCAN_W  = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] code;
    case (d)
      4'd0:    code = 7'b1000000;
      4'd1:    code = 7'b1111001;
      4'd2:    code = 7'b0100100;
      4'd3:    code = 7'b0110000;
      4'd4:    code = 7'b0011001;
      4'd5:    code = 7'b0010010;
      4'd6:    code = 7'b0000010;
      4'd7:    code = 7'b1111000;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0010000;
      default: code = 7'b1111111;
    endcase
    return code;
  endfunction

  // {tens, ones}; 60..63 simply yield tens digit 6.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    return {4'(int'(v) / 10), 4'(int'(v) % 10)};
  endfunction

  logic [SCAN_W-1:0]  scan_cnt_reg, scan_cnt_next;
  logic [1:0]         idx_reg, idx_next;
  logic [BLINK_W-1:0] blink_cnt_reg, blink_cnt_next;
  logic               phase_reg, phase_next;
  logic [5:0]         snap_min_reg, snap_min_next;
  logic [5:0]         snap_sec_reg, snap_sec_next;
  logic [6:0]         seg_reg, seg_next;
  logic [3:0]         an_reg, an_next;
  logic               dp_reg, dp_next;

  logic               scan_wrap;
  logic               frame_end;
  logic               blink_wrap;
  logic               blank;
  logic [7:0]         sec_bcd;
  logic [7:0]         min_bcd;
  logic [3:0]         digit_val [4];
  logic [6:0]         digit_code [4];
  logic [3:0]         digit_an [4];

  assign scan_wrap  = (scan_cnt_reg == SCAN_LAST);
  assign frame_end  = scan_wrap && (idx_reg == 2'd3);
  assign blink_wrap = (blink_cnt_reg == BLINK_LAST);

  assign sec_bcd = to_bcd(snap_sec_reg);
  assign min_bcd = to_bcd(snap_min_reg);

  assign digit_val[0] = sec_bcd[3:0];
  assign digit_val[1] = sec_bcd[7:4];
  assign digit_val[2] = min_bcd[3:0];
  assign digit_val[3] = min_bcd[7:4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign digit_code[gi] = seg_code(digit_val[gi]);
      assign digit_an[gi]   = ~(4'b0001 << gi);
    end
  endgenerate

  // Scan position and the per-frame snapshot.
  always_comb begin
    scan_cnt_next = scan_wrap ? '0 : scan_cnt_reg + 1'b1;
    idx_next      = scan_wrap ? idx_reg + 2'd1 : idx_reg;
    snap_min_next = frame_end ? bus.minutes : snap_min_reg;
    snap_sec_next = frame_end ? bus.seconds : snap_sec_reg;
  end

  // Blink timer only runs in adjust mode; leaving adjust parks it visible.
  always_comb begin
    blink_cnt_next = '0;
    phase_next     = 1'b1;
    if (bus.adj) begin
      blink_cnt_next = blink_wrap ? '0 : blink_cnt_reg + 1'b1;
      phase_next     = blink_wrap ? ~phase_reg : phase_reg;
    end
  end

  // idx[1]=0 is the seconds pair, idx[1]=1 the minutes pair; sel=1 picks seconds.
  assign blank = bus.adj && !phase_reg && (idx_reg[1] != bus.sel);

  always_comb begin
    an_next  = 4'b1111;
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    if (!blank) begin
      an_next  = digit_an[idx_reg];
      seg_next = digit_code[idx_reg];
      dp_next  = (idx_reg != 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstBtn) begin
      scan_cnt_reg  <= '0;
      idx_reg       <= 2'd0;
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b1;
      snap_min_reg  <= 6'd0;
      snap_sec_reg  <= 6'd0;
      seg_reg       <= 7'h7F;
      an_reg        <= 4'b1111;
      dp_reg        <= 1'b1;
    end else begin
      scan_cnt_reg  <= scan_cnt_next;
      idx_reg       <= idx_next;
      blink_cnt_reg <= blink_cnt_next;
      phase_reg     <= phase_next;
      snap_min_reg  <= snap_min_next;
      snap_sec_reg  <= snap_sec_next;
      seg_reg       <= seg_next;
      an_reg        <= an_next;
      dp_reg        <= dp_next;
    end
  end

  assign bus.seg = seg_reg;
  assign bus.an  = an_reg;
  assign bus.dp  = dp_reg;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Randomized and directed bench for sevenseg_scan against a cycle-count based
// reference model of the display timeline.
module tb_sevenseg_scan;
  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 16;
  localparam int FRAME     = 4 * SCAN_DIV;

  logic clk = 1'b0;
  logic rst_btn;
  int   n_checks = 0;
  int   n_errors = 0;

  sevenseg_scan_if bus ();

  sevenseg_scan #(
    .SCAN_DIV (SCAN_DIV),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk   (clk),
    .rstBtn(rst_btn),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  // Model: cycles since reset, latched time, consecutive adjust-mode cycles.
  int m_t;
  int m_snap_min;
  int m_snap_sec;
  int m_adj_run;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    int         idx;
    int         d;
    bit         visible;
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    if (!rst_btn) begin
      m_t = 0; m_snap_min = 0; m_snap_sec = 0; m_adj_run = 0;
    end else begin
      idx     = (m_t / SCAN_DIV) % 4;
      visible = ((m_adj_run / BLINK_DIV) % 2) == 0;
      if (!(bus.adj && !visible && ((idx < 2) == bus.sel))) begin
        case (idx)
          0:       d = m_snap_sec % 10;
          1:       d = m_snap_sec / 10;
          2:       d = m_snap_min % 10;
          default: d = m_snap_min / 10;
        endcase
        e_an[idx] = 1'b0;
        e_seg     = seg_tab[d];
        e_dp      = (idx != 2);
      end
      if (m_t % FRAME == FRAME - 1) begin
        m_snap_min = int'(bus.minutes);
        m_snap_sec = int'(bus.seconds);
      end
      m_t++;
      m_adj_run = bus.adj ? m_adj_run + 1 : 0;
    end
    @(posedge clk);
    #1;
    check("an", 32'(bus.an), 32'(e_an));
    check("seg", 32'(bus.seg), 32'(e_seg));
    check("dp", 32'(bus.dp), 32'(e_dp));
  endtask

  task automatic do_reset(input int n);
    rst_btn = 1'b0;
    for (int i = 0; i < n; i++) cycle();
    rst_btn = 1'b1;
  endtask

  initial begin
    rst_btn     = 1'b0;
    bus.minutes = 6'd0;
    bus.seconds = 6'd0;
    bus.adj     = 1'b0;
    bus.sel     = 1'b0;
    m_t = 0; m_snap_min = 0; m_snap_sec = 0; m_adj_run = 0;

    // Reset, then first digit is '0' on an[0] for SCAN_DIV cycles.
    do_reset(3);
    check("rst_an", 32'(bus.an), 32'h0000000F);
    check("rst_seg", 32'(bus.seg), 32'h0000007F);
    for (int k = 0; k < SCAN_DIV; k++) begin
      cycle();
      check("first_an", 32'(bus.an), 32'b1110);
      check("first_seg", 32'(bus.seg), 32'b1000000);
    end
    $display("txn reset/first-digit done checks=%0d", n_checks);

    // 12:34 with a mid-frame seconds change to 35.
    bus.minutes = 6'd12;
    bus.seconds = 6'd34;
    do_reset(1);
    for (int k = 0; k < 3 * FRAME; k++) begin
      cycle();
      if (k == 16) check("s2_d0", 32'(bus.seg), 32'b0011001);
      if (k == 20) begin
        check("s2_d1", 32'(bus.seg), 32'b0110000);
        bus.seconds = 6'd35;
      end
      if (k == 24) begin
        check("s2_d2", 32'(bus.seg), 32'b0100100);
        check("s2_dp", 32'(bus.dp), 32'd0);
      end
      if (k == 28) check("s2_d3", 32'(bus.seg), 32'b1111001);
      if (k == 32) check("s3_d0", 32'(bus.seg), 32'b0010010);
    end
    $display("txn 12:34->35 done checks=%0d", n_checks);

    // Adjust seconds, then drop adjust.
    bus.adj = 1'b1;
    bus.sel = 1'b1;
    for (int k = 0; k < 5 * BLINK_DIV; k++) cycle();
    bus.sel = 1'b0;
    for (int k = 0; k < 2 * BLINK_DIV + 3; k++) cycle();
    bus.adj = 1'b0;
    for (int k = 0; k < FRAME; k++) cycle();
    $display("txn blink done checks=%0d", n_checks);

    // 63:59 from reset.
    bus.minutes = 6'd63;
    bus.seconds = 6'd59;
    do_reset(1);
    for (int k = 0; k < 2 * FRAME; k++) begin
      cycle();
      if (k == 16) check("s5_d0", 32'(bus.seg), 32'b0010000);
      if (k == 20) check("s5_d1", 32'(bus.seg), 32'b0010010);
      if (k == 24) check("s5_d2", 32'(bus.seg), 32'b0110000);
      if (k == 28) check("s5_d3", 32'(bus.seg), 32'b0000010);
    end
    $display("txn 63:59 done checks=%0d", n_checks);

    // One-cycle reset while idx=2, then scan restarts at idx0 showing zeros.
    for (int k = 0; k < 2 * SCAN_DIV + 1; k++) cycle();
    do_reset(1);
    check("mid_rst_an", 32'(bus.an), 32'h0000000F);
    cycle();
    check("post_rst_an", 32'(bus.an), 32'b1110);
    check("post_rst_seg", 32'(bus.seg), 32'b1000000);
    $display("txn mid-frame reset done checks=%0d", n_checks);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(39, 0) == 0) bus.minutes = 6'($urandom_range(63, 0));
      if ($urandom_range(39, 0) == 0) bus.seconds = 6'($urandom_range(63, 0));
      if ($urandom_range(59, 0) == 0) bus.adj = ~bus.adj;
      if ($urandom_range(49, 0) == 0) bus.sel = ~bus.sel;
      rst_btn = ($urandom_range(299, 0) != 0);
      cycle();
    end
    rst_btn = 1'b1;
    $display("txn random done checks=%0d", n_checks);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
